// File: rtl/corr_dump_fifo.sv
// rtl/corr_dump_fifo.sv - dump-record capture pipeline and FWFT FIFO; optional power stages under CORR_POWER_EN
module corr_dump_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 16,
  parameter int SEQ_W = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      dump,
  input  logic signed [CW-1:0]      i_early,
  input  logic signed [CW-1:0]      q_early,
  input  logic signed [CW-1:0]      i_prompt,
  input  logic signed [CW-1:0]      q_prompt,
  input  logic signed [CW-1:0]      i_late,
  input  logic signed [CW-1:0]      q_late,
  input  logic                      rd_ready,
  input  logic                      clr_ovf,
  output logic                      rd_valid,
  output logic [6*CW-1:0]           rd_corr,
  output logic [SEQ_W-1:0]          rd_seq,
`ifdef CORR_POWER_EN
  output logic [3*32-1:0]           rd_pow,
`endif
  output logic [$clog2(DEPTH):0]    count,
  output logic                      ovf,
  output logic [7:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  // capture stage
  logic                   s0_valid;
  logic [SEQ_W-1:0]       s0_seq;
  logic signed [CW-1:0]   s0_c [6];
  logic [SEQ_W-1:0]       seq_cnt;

  // record presented to the FIFO write port
  logic                   w_valid;
  logic [SEQ_W-1:0]       w_seq;
  logic [6*CW-1:0]        w_corr;

  // FIFO state
  logic [SEQ_W-1:0]       mem_seq  [DEPTH];
  logic [6*CW-1:0]        mem_corr [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Latch the six accumulations and tag them with the running dump sequence number
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s0_valid <= 1'b0;
      s0_seq   <= '0;
      seq_cnt  <= '0;
      for (int k = 0; k < 6; k++) s0_c[k] <= '0;
    end else begin
      s0_valid <= dump;
      if (dump) begin
        s0_seq  <= seq_cnt;
        seq_cnt <= seq_cnt + SEQ_W'(1);
        s0_c[0] <= i_early;
        s0_c[1] <= q_early;
        s0_c[2] <= i_prompt;
        s0_c[3] <= q_prompt;
        s0_c[4] <= i_late;
        s0_c[5] <= q_late;
      end
    end
  end

`ifdef CORR_POWER_EN
  logic                   s1_valid;
  logic [SEQ_W-1:0]       s1_seq;
  logic signed [CW-1:0]   s1_c  [6];
  logic [2*CW-1:0]        s1_sq [6];
  logic                   s2_valid;
  logic [SEQ_W-1:0]       s2_seq;
  logic [6*CW-1:0]        s2_corr;
  logic [31:0]            s2_pow [3];
  logic [3*32-1:0]        w_pow;
  logic [3*32-1:0]        mem_pow [DEPTH];

  // Square of a signed value; the result is never negative
  function automatic logic [2*CW-1:0] sq(input logic signed [CW-1:0] x);
    logic signed [2*CW-1:0] e;
    e = {{CW{x[CW-1]}}, x};
    return e * e;
  endfunction

  // Stage 1: six registered squares, with seq and raw values carried alongside
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_seq   <= '0;
      for (int k = 0; k < 6; k++) begin
        s1_c[k]  <= '0;
        s1_sq[k] <= '0;
      end
    end else begin
      s1_valid <= s0_valid;
      s1_seq   <= s0_seq;
      for (int k = 0; k < 6; k++) begin
        s1_c[k]  <= s0_c[k];
        s1_sq[k] <= sq(s0_c[k]);
      end
    end
  end

  // Stage 2: I^2+Q^2 per arm; max 2*2^30 so 32 bits never overflow
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_seq   <= '0;
      s2_corr  <= '0;
      for (int j = 0; j < 3; j++) s2_pow[j] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_seq   <= s1_seq;
      s2_corr  <= {s1_c[0], s1_c[1], s1_c[2], s1_c[3], s1_c[4], s1_c[5]};
      for (int j = 0; j < 3; j++) s2_pow[j] <= 32'(s1_sq[2*j]) + 32'(s1_sq[2*j+1]);
    end
  end

  assign w_valid = s2_valid;
  assign w_seq   = s2_seq;
  assign w_corr  = s2_corr;
  assign w_pow   = {s2_pow[0], s2_pow[1], s2_pow[2]};
  assign rd_pow  = rd_valid ? mem_pow[rd_ptr] : '0;

  // Power words are stored alongside each record
  always_ff @(posedge clk) begin
    if (push) mem_pow[wr_ptr] <= w_pow;
  end
`else
  assign w_valid = s0_valid;
  assign w_seq   = s0_seq;
  assign w_corr  = {s0_c[0], s0_c[1], s0_c[2], s0_c[3], s0_c[4], s0_c[5]};
`endif

  assign rd_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign pop      = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push     = w_valid & (~full | pop);
  assign drop     = w_valid & full & ~pop;

  assign rd_corr  = rd_valid ? mem_corr[rd_ptr] : '0;
  assign rd_seq   = rd_valid ? mem_seq[rd_ptr]  : '0;

  // Record storage; contents are only meaningful where count says so
  always_ff @(posedge clk) begin
    if (push) begin
      mem_seq[wr_ptr]  <= w_seq;
      mem_corr[wr_ptr] <= w_corr;
    end
  end

  // Pointers, occupancy and overflow bookkeeping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (clr_ovf) begin
        ovf      <= 1'b0;
        drop_cnt <= 8'd0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_corr_dump_fifo.sv
// tb/tb_corr_dump_fifo.sv - randomized and directed bench for corr_dump_fifo against a queue model
module tb_corr_dump_fifo;

  localparam int DEPTH = 8;
`ifdef CORR_POWER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [15:0] seq;
    logic [95:0] corr;
  } rec_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              dump;
  logic signed [15:0] ie, qe, ip, qp, il, ql;
  logic              rd_ready;
  logic              clr_ovf;
  logic              rd_valid;
  logic [95:0]       rd_corr;
  logic [15:0]       rd_seq;
`ifdef CORR_POWER_EN
  logic [95:0]       rd_pow;
`endif
  logic [3:0]        count;
  logic              ovf;
  logic [7:0]        drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  rec_t        q[$];
  logic        pv [LAT];
  rec_t        pr [LAT];
  logic [15:0] mseq;
  logic        movf;
  int          mdrop;

  corr_dump_fifo #(.DEPTH(DEPTH), .CW(16), .SEQ_W(16)) dut (
    .clk(clk), .rstn(rstn), .dump(dump),
    .i_early(ie), .q_early(qe), .i_prompt(ip), .q_prompt(qp), .i_late(il), .q_late(ql),
    .rd_ready(rd_ready), .clr_ovf(clr_ovf),
    .rd_valid(rd_valid), .rd_corr(rd_corr), .rd_seq(rd_seq),
`ifdef CORR_POWER_EN
    .rd_pow(rd_pow),
`endif
    .count(count), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] pow_of(input logic [95:0] c);
    longint v [6];
    logic [31:0] p [3];
    for (int k = 0; k < 6; k++) v[k] = longint'($signed(c[95-16*k -: 16]));
    for (int j = 0; j < 3; j++) p[j] = 32'(v[2*j]*v[2*j] + v[2*j+1]*v[2*j+1]);
    return {p[0], p[1], p[2]};
  endfunction

  // Behavioural model: a delay line of LAT edges feeding a bounded queue
  task automatic model_edge();
    logic wv;
    rec_t w;
    bit   drp;
    if (!rstn) begin
      q.delete();
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pr[i] = '0; end
      mseq = 16'd0; movf = 1'b0; mdrop = 0;
      return;
    end
    wv = pv[LAT-1];
    w  = pr[LAT-1];
    for (int i = LAT-1; i > 0; i--) begin pv[i] = pv[i-1]; pr[i] = pr[i-1]; end
    pv[0] = dump;
    pr[0] = {mseq, ie, qe, ip, qp, il, ql};
    if (dump) mseq = mseq + 16'd1;
    if (q.size() > 0 && rd_ready) void'(q.pop_front());
    drp = 1'b0;
    if (wv) begin
      if (q.size() < DEPTH) q.push_back(w);
      else drp = 1'b1;
    end
    if (clr_ovf) begin
      movf = 1'b0; mdrop = 0;
    end else if (drp) begin
      movf = 1'b1;
      if (mdrop < 255) mdrop++;
    end
  endtask

  task automatic compare_all();
    chk("rd_valid", rd_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("ovf", ovf, movf);
    chk("drop_cnt", drop_cnt, mdrop);
    if (q.size() != 0) begin
      chk("rd_seq", rd_seq, q[0].seq);
      chk("rd_corr", rd_corr, q[0].corr);
`ifdef CORR_POWER_EN
      chk("rd_pow", rd_pow, pow_of(q[0].corr));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_vals();
    {ie, qe} = {$urandom(), $urandom()} >> 0;
    ip = 16'($urandom()); qp = 16'($urandom());
    il = 16'($urandom()); ql = 16'($urandom());
    ie = 16'($urandom()); qe = 16'($urandom());
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; dump = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    repeat (n) step();
    rstn = 1'b1;
  endtask

  task automatic one_dump();
    rand_vals();
    dump = 1'b1;
    step();
    dump = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; dump = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    ie = '0; qe = '0; ip = '0; qp = '0; il = '0; ql = '0;
    do_reset(2);
    chk("reset_valid", rd_valid, 1'b0);
    chk("reset_count", count, 4'd0);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_drop", drop_cnt, 8'd0);
    chk("reset_corr", rd_corr, 96'd0);
    chk("reset_seq", rd_seq, 16'd0);

    // Single known record and its push latency
    ie = 16'sd100; qe = -16'sd50; ip = 16'sd3000; qp = -16'sd400; il = 16'sd20; ql = -16'sd10;
    dump = 1'b1;
    step();
    dump = 1'b0;
    chk("lat_edge_n", rd_valid, 1'b0);
    for (int i = 1; i < LAT; i++) begin
      step();
      chk("lat_early", rd_valid, 1'b0);
    end
    step();
    chk("lat_valid", rd_valid, 1'b1);
    chk("one_corr", rd_corr, {16'sd100, -16'sd50, 16'sd3000, -16'sd400, 16'sd20, -16'sd10});
    chk("one_seq", rd_seq, 16'd0);
`ifdef CORR_POWER_EN
    chk("one_pow", rd_pow, {32'd12500, 32'd9160000, 32'd500});
`endif

    // Nine slow dumps into an eight-deep FIFO
    do_reset(1);
    for (int d = 0; d < 9; d++) begin
      one_dump();
      repeat (999) step();
    end
    chk("ovf_count", count, 4'd8);
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_drop", drop_cnt, 8'd1);
    for (int d = 0; d < 8; d++) begin
      chk("drain_seq", rd_seq, d);
      pop_one();
    end
    chk("drain_empty", rd_valid, 1'b0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", ovf, 1'b0);

    // Full FIFO, write coinciding with a pop
    do_reset(1);
    for (int d = 0; d < 8; d++) one_dump();
    repeat (LAT + 1) step();
    chk("full_count", count, 4'd8);
    one_dump();
    repeat (LAT - 1) step();
    pop_one();
    chk("swap_count", count, 4'd8);
    chk("swap_ovf", ovf, 1'b0);
    chk("swap_head", rd_seq, 16'd1);

    // Back-to-back dumps with incrementing values
    do_reset(1);
    for (int d = 0; d < 4; d++) begin
      ie = 16'(d); qe = 16'(d + 1); ip = 16'(d + 2); qp = 16'(d + 3); il = 16'(d + 4); ql = 16'(d + 5);
      dump = 1'b1;
      step();
    end
    dump = 1'b0;
    repeat (LAT + 1) step();
    chk("burst_count", count, 4'd4);
    for (int d = 0; d < 4; d++) begin
      chk("burst_seq", rd_seq, d);
      chk("burst_ie", rd_corr[95:80], d);
      pop_one();
    end

    // Sequence wrap
    do_reset(1);
    rd_ready = 1'b1;
    dump = 1'b1;
    for (int d = 0; d < 65534; d++) begin
      rand_vals();
      step();
    end
    dump = 1'b0;
    repeat (LAT + 2) step();
    rd_ready = 1'b0;
    chk("wrap_drained", count, 4'd0);
    for (int d = 0; d < 3; d++) one_dump();
    repeat (LAT + 1) step();
    chk("wrap_count", count, 4'd3);
    chk("wrap_seq0", rd_seq, 16'hFFFE);
    pop_one();
    chk("wrap_seq1", rd_seq, 16'hFFFF);
    pop_one();
    chk("wrap_seq2", rd_seq, 16'h0000);
    pop_one();

    // Randomized traffic with occasional clears
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      rand_vals();
      dump     = ($urandom_range(0, 1) == 1);
      rd_ready = ($urandom_range(0, 3) == 0);
      clr_ovf  = ($urandom_range(0, 63) == 0);
      step();
    end
    dump = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;

    // Reset with five records queued
    do_reset(1);
    for (int d = 0; d < 5; d++) one_dump();
    repeat (LAT + 1) step();
    chk("pre_rst_count", count, 4'd5);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst_count", count, 4'd0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    one_dump();
    repeat (LAT) step();
    chk("rst_next_valid", rd_valid, 1'b1);
    chk("rst_next_seq", rd_seq, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
